// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data access.
// One transaction in flight at a time; data wins ties unless fetch has been starved.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned STARVE_MAX   = 4,
   parameter int unsigned STARVE_WIDTH = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   output logic                  if_valid_o,
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   output logic                  d_valid_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic                  mem_gnt_i,
   input  logic                  mem_rvalid_i,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output logic                  stall_f_o,
   output logic                  stall_m_o
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} stateT;
   typedef enum logic {OwnFetch, OwnData} ownerT;

   localparam logic [STARVE_WIDTH-1:0] StarveMax = STARVE_WIDTH'(STARVE_MAX);

   stateT                   stateQ, stateD;
   ownerT                   ownerQ, ownerD;
   logic [STARVE_WIDTH-1:0] starveCntQ, starveCntD;
   logic [ADDR_WIDTH-1:0]   addrQ, addrD;
   logic                    weQ, weD;
   logic [DATA_WIDTH-1:0]   wdataQ, wdataD;
   logic [DATA_WIDTH-1:0]   ifRdataQ, ifRdataD;
   logic [DATA_WIDTH-1:0]   dRdataQ, dRdataD;
   logic                    fetchStarved;
   logic                    takeData;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stateQ     <= StIdle;
         ownerQ     <= OwnFetch;
         starveCntQ <= '0;
         addrQ      <= '0;
         weQ        <= 1'b0;
         wdataQ     <= '0;
         ifRdataQ   <= '0;
         dRdataQ    <= '0;
      end else begin
         stateQ     <= stateD;
         ownerQ     <= ownerD;
         starveCntQ <= starveCntD;
         addrQ      <= addrD;
         weQ        <= weD;
         wdataQ     <= wdataD;
         ifRdataQ   <= ifRdataD;
         dRdataQ    <= dRdataD;
      end
   end

   always_comb begin
      stateD       = stateQ;
      ownerD       = ownerQ;
      starveCntD   = starveCntQ;
      addrD        = addrQ;
      weD          = weQ;
      wdataD       = wdataQ;
      ifRdataD     = ifRdataQ;
      dRdataD      = dRdataQ;
      fetchStarved = starveCntQ >= StarveMax;
      takeData     = d_req_i && (!if_req_i || !fetchStarved);

      unique case (stateQ)
         StIdle: begin
            if (takeData) begin
               ownerD = OwnData;
               addrD  = d_addr_i;
               weD    = d_we_i;
               wdataD = d_wdata_i;
               stateD = StReq;
               // Only grants that made fetch wait count towards starvation.
               if (if_req_i && !fetchStarved) begin
                  starveCntD = starveCntQ + 1'b1;
               end
            end else if (if_req_i) begin
               ownerD     = OwnFetch;
               addrD      = if_addr_i;
               weD        = 1'b0;
               wdataD     = '0;
               starveCntD = '0;
               stateD     = StReq;
            end
         end
         StReq: begin
            if (mem_gnt_i) begin
               stateD = StWait;
            end
         end
         StWait: begin
            if (mem_rvalid_i) begin
               if (ownerQ == OwnFetch) begin
                  ifRdataD = mem_rdata_i;
               end else if (!weQ) begin
                  dRdataD = mem_rdata_i;
               end
               stateD = StResp;
            end
         end
         StResp: begin
            stateD = StIdle;
         end
      endcase
   end

   always_comb begin
      mem_req_o   = stateQ == StReq;
      mem_we_o    = (stateQ == StReq) && weQ;
      mem_addr_o  = addrQ;
      mem_wdata_o = wdataQ;
      if_valid_o  = (stateQ == StResp) && (ownerQ == OwnFetch);
      d_valid_o   = (stateQ == StResp) && (ownerQ == OwnData);
      if_rdata_o  = ifRdataQ;
      d_rdata_o   = dRdataQ;
      stall_f_o   = if_req_i && !if_valid_o;
      stall_m_o   = d_req_i && !d_valid_o;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory responder model, scoreboard of
// expected read data per requester, and per-cycle logs for latency checks.
module tb_mem_port_arbiter;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dOpT;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_rdata_o;
   logic        if_valid_o;
   logic        d_req_i;
   logic        d_we_i;
   logic [31:0] d_addr_i;
   logic [31:0] d_wdata_i;
   logic [31:0] d_rdata_o;
   logic        d_valid_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        stall_f_o;
   logic        stall_m_o;

   logic        respGnt, respRvalid, manGnt, manRvalid;
   logic [31:0] respRdata, manRdata;
   assign mem_gnt_i    = respGnt | manGnt;
   assign mem_rvalid_i = respRvalid | manRvalid;
   assign mem_rdata_i  = manRvalid ? manRdata : respRdata;

   int          total = 0;
   int          bad = 0;
   int          gntDelay = 0;
   int          rvDelay = 0;
   bit          respEnable = 1'b1;
   logic [31:0] memArr [logic [31:0]];
   logic [31:0] refMem [logic [31:0]];
   logic [31:0] rspAddr, rspWdata;
   logic        rspWe;

   logic [31:0] fOps [$];
   dOpT         dOps [$];
   logic [31:0] expF [$];
   logic [31:0] expD [$];
   logic        fActive = 1'b0;
   logic        dActive = 1'b0;
   logic [31:0] lastLoad = '0;
   logic [31:0] ordBits;
   int          ordCnt;

   logic        lgReq [64];
   logic        lgWe  [64];
   logic        lgIfV [64];
   logic        lgDV  [64];
   logic        lgStF [64];
   logic        lgStM [64];
   logic [31:0] lgAddr  [64];
   logic [31:0] lgWdata [64];

   mem_port_arbiter #(
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32),
      .STARVE_MAX  (4),
      .STARVE_WIDTH(3)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_valid_o  (if_valid_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_rdata_o   (d_rdata_o),
      .d_valid_o   (d_valid_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_gnt_i   (mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .stall_f_o   (stall_f_o),
      .stall_m_o   (stall_m_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] defWord(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      return refMem.exists(a) ? refMem[a] : defWord(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory model: grant after gntDelay cycles, respond rvDelay cycles after the grant.
   initial begin
      respGnt    = 1'b0;
      respRvalid = 1'b0;
      respRdata  = '0;
      forever begin
         @(negedge clk_i);
         if (respEnable && mem_req_o) begin
            repeat (gntDelay) @(negedge clk_i);
            respGnt  = 1'b1;
            rspAddr  = mem_addr_o;
            rspWe    = mem_we_o;
            rspWdata = mem_wdata_o;
            @(negedge clk_i);
            respGnt = 1'b0;
            repeat (rvDelay) @(negedge clk_i);
            respRvalid = 1'b1;
            if (rspWe) begin
               memArr[rspAddr] = rspWdata;
               respRdata = 32'hBAD0_BAD0;
            end else begin
               respRdata = memArr.exists(rspAddr) ? memArr[rspAddr] : defWord(rspAddr);
            end
            @(negedge clk_i);
            respRvalid = 1'b0;
            respRdata  = '0;
         end
      end
   end

   task automatic pushD(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      dOpT op;
      op.we = we;
      op.addr = addr;
      op.wdata = wdata;
      dOps.push_back(op);
   endtask

   task automatic present();
      dOpT op;
      if (!fActive && fOps.size() > 0) begin
         fActive   = 1'b1;
         if_req_i  = 1'b1;
         if_addr_i = fOps.pop_front();
         expF.push_back(refRead(if_addr_i));
      end
      if (!dActive && dOps.size() > 0) begin
         op        = dOps.pop_front();
         dActive   = 1'b1;
         d_req_i   = 1'b1;
         d_we_i    = op.we;
         d_addr_i  = op.addr;
         d_wdata_i = op.wdata;
         if (op.we) begin
            refMem[op.addr] = op.wdata;
         end else begin
            lastLoad = refRead(op.addr);
         end
         expD.push_back(lastLoad);
      end
   endtask

   // Cycle 0 is the cycle in which the first requests are presented.
   task automatic runOps(input int budget);
      int cyc;
      cyc     = 0;
      ordBits = '0;
      ordCnt  = 0;
      for (int i = 0; i < 64; i++) begin
         lgReq[i] = 1'b0; lgWe[i] = 1'b0; lgIfV[i] = 1'b0; lgDV[i] = 1'b0;
         lgStF[i] = 1'b0; lgStM[i] = 1'b0; lgAddr[i] = '0; lgWdata[i] = '0;
      end
      present();
      while ((fActive || dActive) && cyc < budget) begin
         @(negedge clk_i);
         if (cyc < 64) begin
            lgReq[cyc] = mem_req_o; lgWe[cyc] = mem_we_o; lgIfV[cyc] = if_valid_o;
            lgDV[cyc] = d_valid_o; lgStF[cyc] = stall_f_o; lgStM[cyc] = stall_m_o;
            lgAddr[cyc] = mem_addr_o; lgWdata[cyc] = mem_wdata_o;
         end
         if (if_valid_o) begin
            ordBits = {ordBits[30:0], 1'b0};
            ordCnt++;
            if (expF.size() > 0) chk("if_rdata", if_rdata_o, expF.pop_front());
            else chk("if_valid_unexpected", if_valid_o, 0);
            fActive = 1'b0;
         end
         if (d_valid_o) begin
            ordBits = {ordBits[30:0], 1'b1};
            ordCnt++;
            if (expD.size() > 0) chk("d_rdata", d_rdata_o, expD.pop_front());
            else chk("d_valid_unexpected", d_valid_o, 0);
            dActive = 1'b0;
         end
         @(posedge clk_i);
         #1;
         if (!fActive) if_req_i = 1'b0;
         if (!dActive) d_req_i = 1'b0;
         present();
         cyc++;
      end
      chk("drain_timeout", fActive || dActive, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int nReq;
      int anyValid;
      int anyReq;
      if_req_i = 1'b0; if_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      manGnt = 1'b0; manRvalid = 1'b0; manRdata = '0;
      memArr[32'h10] = 32'h0050_0093;
      refMem[32'h10] = 32'h0050_0093;

      rst_i = 1'b0;
      #12;
      chk("rst_mem_req", mem_req_o, 0);
      chk("rst_mem_we", mem_we_o, 0);
      chk("rst_valids", {if_valid_o, d_valid_o}, 0);
      chk("rst_mem_addr", mem_addr_o, 0);
      chk("rst_rdata", if_rdata_o | d_rdata_o, 0);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;

      // Fetch only, minimum latency.
      fOps.push_back(32'h10);
      runOps(20);
      chk("f_req_c0", lgReq[0], 0);
      chk("f_req_c1", lgReq[1], 1);
      chk("f_addr_c1", lgAddr[1], 32'h10);
      chk("f_we_c1", lgWe[1], 0);
      chk("f_valid_c2c3", {lgIfV[2], lgIfV[3]}, 2'b01);
      chk("f_stall", {lgStF[0], lgStF[1], lgStF[2], lgStF[3]}, 4'b1110);
      chk("f_count", ordCnt, 1);

      // Simultaneous fetch and load: data first.
      fOps.push_back(32'h20);
      pushD(1'b0, 32'h100, 32'h0);
      runOps(30);
      chk("s_addr_c1", lgAddr[1], 32'h100);
      chk("s_dvalid_c3", lgDV[3], 1);
      chk("s_stallm", {lgStM[0], lgStM[1], lgStM[2], lgStM[3]}, 4'b1110);
      chk("s_req_c4c5", {lgReq[4], lgReq[5]}, 2'b01);
      chk("s_faddr_c5", lgAddr[5], 32'h20);
      chk("s_fvalid_c6c7", {lgIfV[6], lgIfV[7]}, 2'b01);
      chk("s_order", ordBits, 32'b10);

      // Store with delayed grant, then read it back.
      gntDelay = 2;
      pushD(1'b1, 32'h200, 32'hDEAD_BEEF);
      runOps(30);
      chk("st_req_c1_c4", {lgReq[1], lgReq[2], lgReq[3], lgReq[4]}, 4'b1110);
      chk("st_we_c1_c3", {lgWe[1], lgWe[2], lgWe[3]}, 3'b111);
      chk("st_addr_c3", lgAddr[3], 32'h200);
      chk("st_wdata_c1", lgWdata[1], 32'hDEAD_BEEF);
      chk("st_wdata_c3", lgWdata[3], 32'hDEAD_BEEF);
      chk("st_dvalid_c4c5", {lgDV[4], lgDV[5]}, 2'b01);
      gntDelay = 0;
      pushD(1'b0, 32'h200, 32'h0);
      runOps(20);

      // Starvation guard: fetch wins after four data grants, then the counter restarts.
      fOps.push_back(32'h40);
      fOps.push_back(32'h44);
      for (int i = 0; i < 5; i++) pushD(1'b0, 32'h400 + 32'(i * 4), 32'h0);
      runOps(60);
      chk("sv_count", ordCnt, 7);
      chk("sv_order", ordBits, 32'b1111010);

      // Memory back-pressure: a single outstanding request per owner.
      rvDelay = 5;
      pushD(1'b0, 32'h500, 32'h0);
      fOps.push_back(32'h50);
      runOps(40);
      nReq = 0;
      for (int i = 0; i <= 8; i++) nReq += int'(lgReq[i]);
      chk("bp_one_req", nReq, 1);
      chk("bp_dvalid_c7c8", {lgDV[7], lgDV[8]}, 2'b01);
      chk("bp_freq_c10", lgReq[10], 1);
      chk("bp_fvalid_c17", lgIfV[17], 1);
      rvDelay = 0;

      // Reset in the middle of WAIT, then a stale response.
      respEnable = 1'b0;
      d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h300;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("rw_req", mem_req_o, 1);
      manGnt = 1'b1;
      @(negedge clk_i);
      manGnt = 1'b0;
      chk("rw_in_wait", mem_req_o, 0);
      #1;
      rst_i = 1'b0;
      d_req_i = 1'b0;
      #1;
      chk("rw_mem_req", mem_req_o, 0);
      chk("rw_mem_addr", mem_addr_o, 0);
      chk("rw_mem_wdata", mem_wdata_o, 0);
      chk("rw_if_rdata", if_rdata_o, 0);
      chk("rw_d_rdata", d_rdata_o, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      manRvalid = 1'b1;
      manRdata = 32'hFEED_F00D;
      @(negedge clk_i);
      manRvalid = 1'b0;
      anyValid = 0;
      anyReq = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         anyValid += int'(if_valid_o) + int'(d_valid_o);
         anyReq += int'(mem_req_o);
      end
      chk("rw_no_valid", anyValid, 0);
      chk("rw_no_req", anyReq, 0);
      chk("rw_d_rdata_after", d_rdata_o, 0);
      chk("rw_mem_we_after", mem_we_o, 0);

      // Recovery after reset.
      respEnable = 1'b1;
      lastLoad = '0;
      @(posedge clk_i);
      #1;
      fOps.push_back(32'h10);
      runOps(20);
      chk("rec_req_c1", lgReq[1], 1);
      chk("rec_fvalid_c3", lgIfV[3], 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the Fetch stage (instruction reads) and the Memory stage (data loads/stores) of the pipelined core.
- Serialises the two requesters through a registered FSM with one outstanding transaction at a time.
- Data requests have priority, with a starvation guard for fetch.
- Drives the stall signals the hazard unit consumes.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
STARVE_MAX, 4, consecutive data grants made while fetch waits before fetch is forced to win
STARVE_WIDTH, 3, width of the starvation counter; must hold STARVE_MAX

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
if_req_i  in  1  fetch read request; held until if_valid_o
if_addr_i  in  ADDR_WIDTH  fetch address (PCF); stable while if_req_i
if_rdata_o  out  DATA_WIDTH  fetched instruction
if_valid_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request; held until d_valid_o
d_we_i  in  1  1 = store, 0 = load
d_addr_i  in  ADDR_WIDTH  data address (ALUResultM)
d_wdata_i  in  DATA_WIDTH  store data
d_rdata_o  out  DATA_WIDTH  load data
d_valid_o  out  1  one-cycle completion pulse for data
mem_req_o  out  1  request to memory
mem_we_o  out  1  write enable to memory
mem_addr_o  out  ADDR_WIDTH  memory address
mem_wdata_o  out  DATA_WIDTH  memory write data
mem_gnt_i  in  1  memory accepts the request this cycle
mem_rvalid_i  in  1  memory completion (read data or write ack)
mem_rdata_i  in  DATA_WIDTH  memory read data
stall_f_o  out  1  stall Fetch/Decode
stall_m_o  out  1  stall Memory and all older-stage registers

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. The owner register (FETCH/DATA) is latched on leaving IDLE.
- IDLE:
  - If d_req_i and (not if_req_i or starve_cnt < STARVE_MAX): owner = DATA.
  - Else if if_req_i: owner = FETCH.
  - When a request is taken, latch addr, we and wdata, then go to REQ.
  - If neither request is present, stay in IDLE.
- REQ:
  - mem_req_o = 1 and mem_addr_o/mem_we_o/mem_wdata_o are driven from the latched values.
  - mem_we_o = 0 whenever owner = FETCH.
  - Go to WAIT on mem_gnt_i; otherwise hold with all outputs stable.
- WAIT: on mem_rvalid_i, capture mem_rdata_i into if_rdata_o (owner FETCH) or d_rdata_o (owner DATA, load only), then go to RESP.
- RESP:
  - Pulse the owner's valid for exactly one cycle, then go to IDLE.
  - IDLE samples requests only in the cycle after RESP, so a held request is never issued twice.
- Minimum latency: request seen in cycle 0, valid in cycle 3 (gnt in REQ and rvalid in the first WAIT cycle). Each extra gnt or rvalid wait cycle adds 1.
- Starvation counter:
  - Increments, saturating at STARVE_MAX, on each IDLE->REQ transition with owner DATA while if_req_i = 1.
  - Clears to 0 on any IDLE->REQ transition with owner FETCH.
  - Unchanged otherwise.
- Store completion: d_valid_o pulses; d_rdata_o holds its previous value.
- Captured rdata outputs hold until overwritten by the next completion for the same requester.
- stall_f_o = if_req_i and not if_valid_o (combinational).
- stall_m_o = d_req_i and not d_valid_o (combinational).
- mem_rvalid_i outside WAIT is ignored, including stale responses after reset.
- mem_gnt_i outside REQ is ignored.
- Reset (asynchronous, any state, including mid-transaction):
  - State = IDLE, owner = FETCH, starve_cnt = 0.
  - mem_req_o, mem_we_o, if_valid_o and d_valid_o = 0.
  - mem_addr_o, mem_wdata_o, if_rdata_o and d_rdata_o = 0.
  - An in-flight transaction is abandoned. Requesters re-issue after reset.

Test Plan:
- Fetch only: if_addr_i = 0x0000_0010, gnt immediate, rvalid with 0x0050_0093 in the first WAIT cycle -> mem_req_o on cycle 1, if_valid_o on cycle 3, if_rdata_o = 0x0050_0093, stall_f_o high on cycles 0-2.
- Simultaneous requests: if_req_i and d_req_i (load 0x100) in the same cycle -> data is served first (d_valid_o at cycle 3, starve_cnt = 1), fetch issues at cycle 5 (mem_req_o high with if_addr_i), if_valid_o at cycle 7.
- Store: d_we_i = 1, addr 0x200, wdata 0xDEAD_BEEF, gnt delayed 2 cycles -> mem_we_o = 1 and outputs stable across the wait, d_valid_o at cycle 5, d_rdata_o unchanged.
- Starvation: if_req_i held high while d_req_i is re-asserted back-to-back, STARVE_MAX = 4 -> exactly 4 data transactions complete, then fetch is granted and starve_cnt returns to 0.
- Reset mid-WAIT: assert rst_i low while in WAIT, then pulse mem_rvalid_i after release -> no valid pulse, FSM in IDLE, all outputs 0.
- Memory back-pressure: rvalid delayed 5 cycles -> only one outstanding request, no second mem_req_o before the owner's valid.
